// File: rtl/vector_loader_pkg.sv
// ============================================================================
// vector_loader_pkg : shared types and constants for the vector frame loader
// Rev 1.0
// ============================================================================
`default_nettype none

package vector_loader_pkg;

  typedef logic [7:0] data_t;
  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GET_N    = 2'd1,
    S_GET_DATA = 2'd2,
    S_GET_END  = 2'd3
  } loader_state_e;

  localparam int    LOADER_MAX_N      = 8;
  localparam data_t LOADER_START_BYTE = 8'hFE;
  localparam data_t LOADER_END_BYTE   = 8'hEF;

endpackage : vector_loader_pkg

`default_nettype wire

// File: rtl/vector_loader.sv
// ============================================================================
// vector_loader : parses UART bytes (start, N, N elements, end) into FIFO pushes
// Rev 1.0
// ============================================================================
`default_nettype none

module vector_loader
  import vector_loader_pkg::*;
#(
  parameter int    MAX_N      = LOADER_MAX_N,
  parameter data_t START_BYTE = LOADER_START_BYTE,
  parameter data_t END_BYTE   = LOADER_END_BYTE
) (
  input  logic    clk,
  input  logic    rst,
  input  data_t   rx_data,
  input  logic    rx_valid,
  output logic    push,
  output data_t   data_out,
  output nibble_t N,
  output logic    busy,
  output logic    done,
  output logic    err
);

  localparam nibble_t C_MAX_N = nibble_t'(MAX_N);

  loader_state_e state_q, state_d;
  nibble_t       cnt_q, cnt_d;
  nibble_t       n_q, n_d;
  data_t         data_q, data_d;
  logic          push_q, push_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  nibble_t w_nib;
  logic    w_nib_ok;

  assign w_nib    = rx_data[3:0];
  assign w_nib_ok = (w_nib != 4'd0) && (w_nib <= C_MAX_N);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    data_d  = data_q;
    push_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == START_BYTE) begin
            state_d = S_GET_N;
          end
        end
        S_GET_N: begin
          if (w_nib_ok) begin
            n_d     = w_nib;
            cnt_d   = 4'd0;
            state_d = S_GET_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_GET_DATA: begin
          data_d = rx_data;
          push_d = 1'b1;
          cnt_d  = cnt_q + 4'd1;
          if ((cnt_q + 4'd1) == n_q) begin
            state_d = S_GET_END;
          end
        end
        S_GET_END: begin
          // Pushed elements are left in the FIFO; control clears it on err.
          if (rx_data == END_BYTE) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      n_q     <= 4'd0;
      data_q  <= 8'd0;
      push_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      data_q  <= data_d;
      push_q  <= push_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign push     = push_q;
  assign data_out = data_q;
  assign N        = n_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule : vector_loader

`default_nettype wire

// File: tb/tb_vector_loader.sv
// ============================================================================
// tb_vector_loader : scoreboard bench; frames are described abstractly and the
// expected pushes/events are queued as each frame is issued.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vector_loader;

  localparam int MAX_N = 8;

  typedef struct {
    logic [7:0] data;
    logic [3:0] n;
  } push_t;

  typedef struct {
    bit         is_done;
    logic [3:0] n;
  } event_t;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       push;
  logic [7:0] data_out;
  logic [3:0] N;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  push_t      pq[$];
  event_t     evq[$];
  logic [7:0] payload[$];
  logic [3:0] exp_n;
  logic       last_v;

  vector_loader dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .push     (push),
    .data_out (data_out),
    .N        (N),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) last_v <= rx_valid;

  // Monitor: every output strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      if (push) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL push_unexpected: got data %h N %h, expected none", data_out, N);
        end else begin
          push_t e;
          e = pq.pop_front();
          if (data_out !== e.data || N !== e.n || last_v !== 1'b1) begin
            errors++;
            $display("FAIL push_data: got data %h N %h prev_valid %b, expected data %h N %h prev_valid 1",
                     data_out, N, last_v, e.data, e.n);
          end
        end
      end
      if (done || err) begin
        checks++;
        if (evq.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected: got done %b err %b, expected none", done, err);
        end else begin
          event_t e;
          e = evq.pop_front();
          if (done !== e.is_done || err !== !e.is_done || N !== e.n || busy !== 1'b0 || last_v !== 1'b1) begin
            errors++;
            $display("FAIL event: got done %b err %b N %h busy %b prev_valid %b, expected done %b err %b N %h busy 0 prev_valid 1",
                     done, err, N, busy, last_v, e.is_done, !e.is_done, e.n);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_busy(input logic expv, input string name);
    checks++;
    if (busy !== expv) begin
      errors++;
      $display("FAIL %s: got busy %b, expected %b", name, busy, expv);
    end
  endtask

  // Frame = start, length byte, payload (when length is legal), end byte.
  task automatic frame(input logic [7:0] nbyte, input logic [7:0] endb, input int gap);
    logic [3:0] nib;
    push_t p;
    event_t e;
    nib = nbyte[3:0];
    send_byte(8'hFE, gap);
    check_busy(1'b1, "busy_in_frame");
    if (nib == 4'd0 || int'(nib) > MAX_N) begin
      e.is_done = 1'b0;
      e.n       = exp_n;
      evq.push_back(e);
      send_byte(nbyte, gap);
    end else begin
      send_byte(nbyte, gap);
      exp_n = nib;
      for (int i = 0; i < int'(nib); i++) begin
        p.data = payload[i];
        p.n    = nib;
        pq.push_back(p);
        send_byte(payload[i], gap);
      end
      e.is_done = (endb == 8'hEF);
      e.n       = nib;
      evq.push_back(e);
      send_byte(endb, gap);
    end
    payload.delete();
    idle_cycles(2);
    check_busy(1'b0, "busy_after_frame");
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (push !== 1'b0 || data_out !== 8'h00 || N !== 4'h0 || done !== 1'b0 ||
        err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got push %b data %h N %h done %b err %b busy %b, expected all zero",
               name, push, data_out, N, done, err, busy);
    end
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    int n;
    int r;

    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_n    = 4'h0;
    idle_cycles(3);
    check_reset_outputs("reset_state");
    rst = 1'b1;
    idle_cycles(2);

    // Nominal frame with gapped bytes
    payload = '{8'h11, 8'h22, 8'h33};
    frame(8'h03, 8'hEF, 2);

    // Back-to-back frame, rx_valid held high
    for (int i = 0; i < 8; i++) payload.push_back(8'(i));
    frame(8'h08, 8'hEF, 0);

    // Bad lengths leave N unchanged
    frame(8'h00, 8'hEF, 1);
    frame(8'h09, 8'hEF, 0);

    // Bad end byte, then a valid frame
    payload = '{8'hAA, 8'hBB};
    frame(8'h02, 8'h55, 1);
    payload = '{8'hFE, 8'hEF, 8'h5A};
    frame(8'hA3, 8'hEF, 0);

    // Noise in idle
    send_byte(8'h00, 1);
    send_byte(8'hEF, 1);
    send_byte(8'h13, 1);
    idle_cycles(2);
    check_busy(1'b0, "busy_after_noise");

    // Reset mid-frame: two elements already pushed, no event expected
    begin
      push_t p;
      p.n = 4'h4;
      send_byte(8'hFE, 0);
      send_byte(8'h04, 0);
      p.data = 8'h01; pq.push_back(p);
      send_byte(8'h01, 0);
      p.data = 8'h02; pq.push_back(p);
      send_byte(8'h02, 0);
      idle_cycles(2);
      #2 rst = 1'b0;
      exp_n = 4'h0;
      #1 check_reset_outputs("reset_mid_frame");
      idle_cycles(2);
      rst = 1'b1;
      idle_cycles(1);
      check_reset_outputs("after_reset_release");
    end
    payload = '{8'h7F};
    frame(8'h01, 8'hEF, 1);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          n = $urandom_range(1, MAX_N);
          for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
          frame({4'($urandom), 4'(n)}, 8'hEF, -1);
        end
        1: begin
          r = $urandom_range(0, 7);
          frame({4'($urandom), (r == 0) ? 4'd0 : 4'(8 + r)}, 8'hEF, -1);
        end
        2: begin
          n = $urandom_range(1, MAX_N);
          for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
          do b = 8'($urandom); while (b == 8'hEF);
          frame({4'($urandom), 4'(n)}, b, -1);
        end
        default: begin
          for (int i = 0; i < 3; i++) begin
            do b = 8'($urandom); while (b == 8'hFE);
            send_byte(b, -1);
          end
          idle_cycles(2);
          check_busy(1'b0, "busy_after_rand_noise");
        end
      endcase
    end

    idle_cycles(5);
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL push_missing: got %0d pushes outstanding, expected 0", pq.size());
    end
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL event_missing: got %0d events outstanding, expected 0", evq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vector_loader

`default_nettype wire
